// File: rtl/crc_block_ctrl.sv
// CRC-32/MPEG-2 over a block of SRAM words, with host write access to the SRAM while idle.
// Reads are issued one per cycle; each word is folded into the accumulator in the cycle after its read.
module crc_block_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] crc_out,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_wr_accept,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [DATA_WIDTH-1:0] CRC_INIT = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] CRC_POLY = DATA_WIDTH'(32'h04C1_1DB7);
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One full word step, MSB-first, no reflection.
  function automatic logic [DATA_WIDTH-1:0] crc_step(
    input logic [DATA_WIDTH-1:0] crc,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (c[DATA_WIDTH-1]) begin
        c = (c << 1) ^ CRC_POLY;
      end else begin
        c = c << 1;
      end
    end
    return c;
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_pend;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_crc_out;
  logic [DATA_WIDTH-1:0] w_fold;
  logic                  w_accept;
  logic                  w_csb;
  logic                  w_web;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;

  assign w_fold   = crc_step(r_acc, sram_dout);
  assign w_accept = host_we & (r_state == S_IDLE);

  // Next-state decode; len is already modulo 2^(ADDR_WIDTH+1) by its width, so every value terminates.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != LEN_ZERO) begin
            w_next = S_RUN;
          end else begin
            w_next = S_DONE;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_remain == LEN_ONE) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, address/count, accumulator and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= {ADDR_WIDTH{1'b0}};
      r_remain  <= LEN_ZERO;
      r_acc     <= CRC_INIT;
      r_pend    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc_out <= CRC_INIT;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      // A read issued this cycle returns data next cycle.
      r_pend  <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= base_addr;
            r_remain <= len;
            r_acc    <= CRC_INIT;
            if (len == LEN_ZERO) begin
              r_crc_out <= CRC_INIT;
            end
          end
        end
        S_RUN: begin
          r_addr   <= r_addr + ADDR_ONE;
          r_remain <= r_remain - LEN_ONE;
          if (r_pend) begin
            r_acc <= w_fold;
          end
        end
        S_DRAIN: begin
          r_acc     <= w_fold;
          r_crc_out <= w_fold;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // SRAM port mux: block reads take the port in RUN, host writes only in IDLE.
  always_comb begin
    w_csb  = 1'b1;
    w_web  = 1'b1;
    w_addr = {ADDR_WIDTH{1'b0}};
    w_din  = {DATA_WIDTH{1'b0}};
    if (r_state == S_RUN) begin
      w_csb  = 1'b0;
      w_addr = r_addr;
    end else if (w_accept) begin
      w_csb  = 1'b0;
      w_web  = 1'b0;
      w_addr = host_addr;
      w_din  = host_wdata;
    end else begin
      w_csb  = 1'b1;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign crc_out        = r_crc_out;
  assign host_wr_accept = w_accept;
  assign sram_csb       = w_csb;
  assign sram_web       = w_web;
  assign sram_addr      = w_addr;
  assign sram_din       = w_din;

endmodule

// File: doc/crc_block_ctrl.md
CRC_BLOCK_CTRL -- requirements
Module: crc_block_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SRAM word-address width (1024 x 32 macro).
REQ-002 Parameter DATA_WIDTH, default 32, SRAM word and CRC width.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 Ports SHALL be:
  clk  in  1  rising-edge clock
  rst_n  in  1  synchronous active-low reset
  start  in  1  request CRC over a block; sampled in IDLE only
  base_addr  in  ADDR_WIDTH  first word address; sampled with start
  len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with start
  busy  out  1  high from the cycle after start until done inclusive
  done  out  1  one-cycle completion pulse
  crc_out  out  DATA_WIDTH  result; held until the next accepted start
  host_we  in  1  host write request
  host_addr  in  ADDR_WIDTH  host write address
  host_wdata  in  DATA_WIDTH  host write data
  host_wr_accept  out  1  combinational; high when the host write is performed this cycle
  sram_csb  out  1  SRAM chip select, active-low
  sram_web  out  1  SRAM write enable, active-low
  sram_addr  out  ADDR_WIDTH  SRAM address
  sram_din  out  DATA_WIDTH  SRAM write data
  sram_dout  in  DATA_WIDTH  SRAM read data, valid one cycle after a read is issued

Function
REQ-005 The CRC SHALL be CRC-32/MPEG-2: poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR, one 32-bit word per step.
REQ-006 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE: start=1 with len>0 -> RUN; latch base_addr and len; clear the accumulator to 0xFFFFFFFF.
REQ-008 IDLE: start=1 with len=0 -> DONE; crc_out=0xFFFFFFFF.
REQ-009 RUN: issue one read per cycle (sram_csb=0, sram_web=1), addresses base, base+1, ... modulo 2^ADDR_WIDTH; wrap past the top address SHALL NOT be flagged.
REQ-010 RUN -> DRAIN in the cycle the len-th read is issued.
REQ-011 The accumulator SHALL fold sram_dout in each cycle following a read issue (RUN after the first issue, and DRAIN); DRAIN -> DONE.
REQ-012 DONE: done=1 for exactly one cycle; crc_out = final accumulator; -> IDLE.
REQ-013 Latency: start accepted at cycle T gives done at T+len+2 for len>0, and at T+1 for len=0.
REQ-014 busy SHALL be high in RUN, DRAIN and DONE, and low in IDLE.
REQ-015 start SHALL be ignored while busy.
REQ-016 Host write: host_wr_accept = host_we AND state==IDLE; when accepted, sram_csb=0, sram_web=0, sram_addr=host_addr, sram_din=host_wdata.
REQ-017 A host write while busy SHALL be rejected (host_wr_accept=0) and not queued; the host retries.
REQ-018 start and host_we in the same IDLE cycle: both SHALL be accepted; the write completes that cycle and subsequent reads observe it.
REQ-019 With no read or accepted write: sram_csb=1, sram_web=1, sram_addr=0, sram_din=0.
REQ-020 len > 2^ADDR_WIDTH is illegal; the block SHALL treat it as len mod 2^(ADDR_WIDTH+1) without a hang.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force: IDLE, busy=0, done=0, crc_out=0xFFFFFFFF, accumulator=0xFFFFFFFF, sram_csb=1, sram_web=1.
REQ-022 Reset mid-operation SHALL abort without a done pulse; the first start after reset release SHALL behave as from power-up.

Verification
REQ-023 Host writes 0xFFFFFFFF @0x000 and 0x00000000 @0x001; start base=0, len=2 at T -> done at T+4, crc_out=0x00000000, busy high T+1..T+4.
REQ-024 start len=0 -> done at T+1, crc_out=0xFFFFFFFF, no SRAM access (sram_csb=1 throughout).
REQ-025 base=0x3FF, len=2 -> read addresses 0x3FF then 0x000; crc_out matches a software MPEG-2 model.
REQ-026 host_we held high during a len=4 run -> host_wr_accept=0 for 6 cycles, memory unchanged; the write is accepted in the first IDLE cycle.
REQ-027 rst_n pulsed low at T+2 of a len=8 run -> no done pulse, crc_out=0xFFFFFFFF, sram_csb=1; a following len=1 run over 0xFFFFFFFF gives 0x00000000.
REQ-028 start and host_we same cycle (write 0xFFFFFFFF @0x010, start base=0x010, len=1) -> crc_out=0x00000000 at T+3.
